// File: rtl/dma_axi_pkg.sv
// Shared definitions for the DMA AXI masters.
//   BURST_INCR / RESP_OKAY : AXI encodings used by the masters
//   dma_wr_state_e         : write-master sequencing states
//   axsize()               : AxSIZE encoding for a given data width
package dma_axi_pkg;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_RESP = 3'd3,
      ST_DONE = 3'd4
   } dma_wr_state_e;

   function automatic logic [2:0] axsize(input int data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock FIFO shared by the DMA read and write masters.
//   ACLK, ARESETn : clock, async active-low reset (empties the FIFO)
//   push, wdata   : write request/data; ignored while full
//   pop, rdata    : read request; rdata is the current head (show-ahead)
//   full, empty   : occupancy flags, registered-pointer based
// Full/empty are evaluated from the pointers at the start of the cycle, so a
// push while full is refused even if a pop happens in the same cycle.
module dma_sync_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 8
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W:0]   r_wr_ptr;
   logic [PTR_W:0]   r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty  = (r_wr_ptr == r_rd_ptr);
   assign full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign rdata  = r_mem[r_rd_ptr[PTR_W-1:0]];

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= wdata;
   end

endmodule

// File: rtl/dma_axi_write_master.sv
// AXI4 write master for the DMA engine: one command (address, beat count, ID)
// is split into INCR bursts of at most MAX_BURST beats, one burst outstanding.
//   ACLK, ARESETn                      : clock, async active-low reset
//   cmd_valid/ready, cmd_addr/len/id   : transfer command
//   in_valid/ready, in_data/strb       : write-data stream into the FIFO
//   AW*/W*/B*                          : AXI4 write channels
//   busy, done, err                    : status; err qualifies the done pulse
// Optional build macro: DMA_WR_4K_SPLIT_EN -- also limit each burst so that it
// never crosses a 4 KB boundary.
//
// state | meaning
// IDLE  | ready for a command
// ADDR  | AW presented for the current burst
// DATA  | streaming the burst's beats from the FIFO
// RESP  | waiting for the burst's B response
// DONE  | one-cycle completion pulse
module dma_axi_write_master
   import dma_axi_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int ID_W       = 4,
   parameter int LEN_W      = 16,
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [LEN_W-1:0]    cmd_len,
   input  logic [ID_W-1:0]     cmd_id,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   input  logic [DATA_W/8-1:0] in_strb,
   output logic [ID_W-1:0]     AWID,
   output logic [ADDR_W-1:0]   AWADDR,
   output logic [3:0]          AWLEN,
   output logic [2:0]          AWSIZE,
   output logic [1:0]          AWBURST,
   output logic                AWVALID,
   input  logic                AWREADY,
   output logic [DATA_W-1:0]   WDATA,
   output logic [DATA_W/8-1:0] WSTRB,
   output logic                WLAST,
   output logic                WVALID,
   input  logic                WREADY,
   input  logic [ID_W-1:0]     BID,
   input  logic [1:0]          BRESP,
   input  logic                BVALID,
   output logic                BREADY,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int         STRB_W = DATA_W / 8;
   localparam logic [2:0] SIZE   = axsize(DATA_W);
   localparam int         BEAT_W = $clog2(MAX_BURST) + 1;

   dma_wr_state_e        r_state;
   logic [ADDR_W-1:0]    r_addr;
   logic [LEN_W-1:0]     r_rem;
   logic [ID_W-1:0]      r_id;
   logic                 r_err;
   logic [BEAT_W-1:0]    r_beats;
   logic [BEAT_W-1:0]    r_cnt;

   logic [BEAT_W-1:0]    w_beats;
   logic [BEAT_W-1:0]    w_len_m1;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic                 w_wfire;
   logic [STRB_W+DATA_W-1:0] w_fifo_rdata;
`ifdef DMA_WR_4K_SPLIT_EN
   logic [12:0]          w_to_4k;
`endif

   // Burst size comes from the registered address/remaining count, so it is
   // stable for the whole ADDR phase.
   always_comb begin
      w_beats = (r_rem < LEN_W'(MAX_BURST)) ? BEAT_W'(r_rem) : BEAT_W'(MAX_BURST);
`ifdef DMA_WR_4K_SPLIT_EN
      w_to_4k = (13'd4096 - {1'b0, r_addr[11:0]}) >> SIZE;
      if (w_to_4k < 13'(w_beats)) w_beats = BEAT_W'(w_to_4k);
`endif
   end

   assign w_len_m1 = w_beats - BEAT_W'(1);

   assign cmd_ready = (r_state == ST_IDLE);
   assign AWVALID   = (r_state == ST_ADDR);
   assign AWADDR    = r_addr;
   assign AWID      = r_id;
   assign AWLEN     = 4'(w_len_m1);
   assign AWSIZE    = SIZE;
   assign AWBURST   = BURST_INCR;
   assign WVALID    = (r_state == ST_DATA) && !w_fifo_empty;
   assign WLAST     = WVALID && (r_cnt == r_beats - BEAT_W'(1));
   assign WDATA     = w_fifo_rdata[DATA_W-1:0];
   assign WSTRB     = w_fifo_rdata[STRB_W+DATA_W-1:DATA_W];
   assign BREADY    = (r_state == ST_RESP);
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_DONE);
   assign err       = (r_state == ST_DONE) && r_err;
   assign in_ready  = !w_fifo_full;
   assign w_wfire   = WVALID && WREADY;

   dma_sync_fifo #(
      .WIDTH (STRB_W + DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .push    (in_valid),
      .pop     (w_wfire),
      .wdata   ({in_strb, in_data}),
      .rdata   (w_fifo_rdata),
      .full    (w_fifo_full),
      .empty   (w_fifo_empty)
   );

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_rem   <= '0;
         r_id    <= '0;
         r_err   <= 1'b0;
         r_beats <= '0;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_addr  <= cmd_addr;
                  r_rem   <= cmd_len;
                  r_id    <= cmd_id;
                  r_err   <= 1'b0;
                  r_state <= (cmd_len == '0) ? ST_DONE : ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (AWREADY) begin
                  r_beats <= w_beats;
                  r_cnt   <= '0;
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_wfire) begin
                  r_cnt <= r_cnt + BEAT_W'(1);
                  if (WLAST) r_state <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (BVALID) begin
                  if (BRESP != RESP_OKAY || BID != r_id) r_err <= 1'b1;
                  r_rem   <= r_rem - LEN_W'(r_beats);
                  r_addr  <= r_addr + (ADDR_W'(r_beats) << SIZE);
                  r_state <= (r_rem == LEN_W'(r_beats)) ? ST_DONE : ST_ADDR;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
